// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M types for the iterative multiply/divide unit: funct3 encodings,
// FSM states and the iteration count.
package rv32i_types;

  localparam int MULDIV_ITERS = 32;
  localparam logic [4:0] MULDIV_LAST = 5'(MULDIV_ITERS - 1);

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_unit_if;
  import rv32i_types::*;

  logic        m_extension_load;
  m_funct3_t   funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        advance;
  logic        flush;
  logic        m_extension_resp;
  logic [31:0] m_extension_result;
  logic        busy;

  modport master (
    output m_extension_load, funct3, rs1_data, rs2_data, advance, flush,
    input  m_extension_resp, m_extension_result, busy
  );

  modport slave (
    input  m_extension_load, funct3, rs1_data, rs2_data, advance, flush,
    output m_extension_resp, m_extension_result, busy
  );
endinterface

// File: rtl/muldiv_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes going in, sign correction
// and hi/lo/quotient/remainder selection coming out.
module muldiv_sign_fix
  import rv32i_types::*;
(
  input  m_funct3_t   funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [63:0] prod_raw,
  input  logic [31:0] quo_raw,
  input  logic [31:0] rem_raw,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic [31:0] result
);

  logic        signed_a_s;
  logic        signed_b_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;

  // Decode operand signedness, strip signs, then restore them on the result
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (funct3)
      MULH, DIV, REM: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b1;
      end
      MULHSU:  signed_a_s = 1'b1;
      default: signed_a_s = 1'b0;
    endcase

    neg_a_s    = signed_a_s & op_a[31];
    neg_b_s    = signed_b_s & op_b[31];
    mag_a      = cond_neg32(op_a, neg_a_s);
    mag_b      = cond_neg32(op_b, neg_b_s);
    prod_fix_s = cond_neg64(prod_raw, neg_a_s ^ neg_b_s);
    quo_fix_s  = cond_neg32(quo_raw, neg_a_s ^ neg_b_s);
    // Remainder follows the dividend's sign only
    rem_fix_s  = cond_neg32(rem_raw, neg_a_s);

    case (funct3)
      MUL:                 result = prod_fix_s[31:0];
      MULH, MULHSU, MULHU: result = prod_fix_s[63:32];
      DIV, DIVU:           result = quo_fix_s;
      REM, REMU:           result = rem_fix_s;
      default:             result = 32'd0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle over 32 cycles, with a registered result/response handshake.
module muldiv_unit
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  muldiv_state_t   state_r, state_next_s;
  logic [4:0]      count_r, count_next_s;
  logic [XLEN-1:0] a_r, a_next_s;
  logic [XLEN-1:0] b_r, b_next_s;
  m_funct3_t       f3_r, f3_next_s;
  logic [63:0]     acc_r, acc_next_s, acc_step_s;
  logic [31:0]     rem_r, rem_next_s, rem_step_s;
  logic [31:0]     quo_r, quo_next_s, quo_step_s;
  logic [32:0]     rem_shift_s;
  logic [31:0]     result_r, result_next_s;
  logic            resp_r, busy_r;
  logic [4:0]      idx_s;
  logic [31:0]     mag_a_s, mag_b_s, fixed_s;
  logic            special_s;
  logic [31:0]     special_val_s;
  logic            div_zero_s, div_ovf_s;

  muldiv_sign_fix u_sign_fix (
    .funct3   (f3_r),
    .op_a     (a_r),
    .op_b     (b_r),
    .prod_raw (acc_step_s),
    .quo_raw  (quo_step_s),
    .rem_raw  (rem_step_s),
    .mag_a    (mag_a_s),
    .mag_b    (mag_b_s),
    .result   (fixed_s)
  );

  // One MSB-first iteration of both the multiplier and the restoring divider
  always_comb begin
    idx_s       = MULDIV_LAST - count_r;
    acc_step_s  = (acc_r << 1) + (mag_b_s[idx_s] ? {32'd0, mag_a_s} : 64'd0);
    rem_shift_s = {rem_r, mag_a_s[idx_s]};
    if (rem_shift_s >= {1'b0, mag_b_s}) begin
      rem_step_s = rem_shift_s[31:0] - mag_b_s;
      quo_step_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_step_s = rem_shift_s[31:0];
      quo_step_s = {quo_r[30:0], 1'b0};
    end
  end

  // Divide cases resolved at load time without iterating
  always_comb begin
    special_s     = 1'b0;
    special_val_s = 32'd0;
    div_zero_s    = (bus.rs2_data == 32'd0);
    div_ovf_s     = (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);
    case (bus.funct3)
      DIV, DIVU: begin
        if (div_zero_s) begin
          special_s     = 1'b1;
          special_val_s = 32'hFFFF_FFFF;
        end else if (div_ovf_s && (bus.funct3 == DIV)) begin
          special_s     = 1'b1;
          special_val_s = 32'h8000_0000;
        end else begin
          special_s     = 1'b0;
        end
      end
      REM, REMU: begin
        if (div_zero_s) begin
          special_s     = 1'b1;
          special_val_s = bus.rs1_data;
        end else if (div_ovf_s && (bus.funct3 == REM)) begin
          special_s     = 1'b1;
          special_val_s = 32'd0;
        end else begin
          special_s     = 1'b0;
        end
      end
      default: special_s = 1'b0;
    endcase
  end

  // Next-state and datapath update; flush always wins
  always_comb begin
    state_next_s  = state_r;
    count_next_s  = count_r;
    a_next_s      = a_r;
    b_next_s      = b_r;
    f3_next_s     = f3_r;
    acc_next_s    = acc_r;
    rem_next_s    = rem_r;
    quo_next_s    = quo_r;
    result_next_s = result_r;
    case (state_r)
      IDLE: begin
        if (bus.m_extension_load && !bus.flush) begin
          a_next_s     = bus.rs1_data;
          b_next_s     = bus.rs2_data;
          f3_next_s    = bus.funct3;
          count_next_s = 5'd0;
          acc_next_s   = 64'd0;
          rem_next_s   = 32'd0;
          quo_next_s   = 32'd0;
          if (special_s) begin
            state_next_s  = DONE;
            result_next_s = special_val_s;
          end else begin
            state_next_s  = BUSY;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.flush || !bus.m_extension_load) begin
          state_next_s = IDLE;
        end else begin
          count_next_s = count_r + 5'd1;
          acc_next_s   = acc_step_s;
          rem_next_s   = rem_step_s;
          quo_next_s   = quo_step_s;
          if (count_r == MULDIV_LAST) begin
            state_next_s  = DONE;
            result_next_s = fixed_s;
          end else begin
            state_next_s  = BUSY;
          end
        end
      end
      DONE: begin
        // Holds regardless of load until the pipeline consumes the result
        if (bus.flush || bus.advance) begin
          state_next_s  = IDLE;
          result_next_s = 32'd0;
        end else begin
          state_next_s  = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      count_r  <= 5'd0;
      a_r      <= '0;
      b_r      <= '0;
      f3_r     <= MUL;
      acc_r    <= 64'd0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      result_r <= 32'd0;
      resp_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      count_r  <= count_next_s;
      a_r      <= a_next_s;
      b_r      <= b_next_s;
      f3_r     <= f3_next_s;
      acc_r    <= acc_next_s;
      rem_r    <= rem_next_s;
      quo_r    <= quo_next_s;
      result_r <= result_next_s;
      resp_r   <= (state_next_s == DONE);
      busy_r   <= (state_next_s == BUSY);
    end
  end

  assign bus.m_extension_resp   = resp_r;
  assign bus.m_extension_result = result_r;
  assign bus.busy               = busy_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hold, flush and reset sequences.
module tb_muldiv_unit;
  import rv32i_types::*;

  typedef struct {
    m_funct3_t   f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  vec_t  vecs[16];
  logic  seen_resp;

  muldiv_unit_if mif();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Load in cycle 0, expect resp in cycle lat, advance there, expect IDLE after
  task automatic run_op(input m_funct3_t f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    @(posedge clk); #1;
    mif.funct3           = f3;
    mif.rs1_data         = a;
    mif.rs2_data         = b;
    mif.advance          = 1'b0;
    mif.m_extension_load = 1'b1;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1 && lat > 1) check({name, "_busy"}, {31'd0, mif.busy}, 32'd1);
      if (cyc == lat - 1 && lat > 1) check({name, "_early"}, {31'd0, mif.m_extension_resp}, 32'd0);
    end
    check({name, "_resp"}, {31'd0, mif.m_extension_resp}, 32'd1);
    check({name, "_result"}, mif.m_extension_result, exp);
    check({name, "_busydone"}, {31'd0, mif.busy}, 32'd0);
    mif.advance = 1'b1;
    @(posedge clk); #1;
    mif.m_extension_load = 1'b0;
    mif.advance          = 1'b0;
    check({name, "_idle"}, {30'd0, mif.m_extension_resp, mif.busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7xm3"};
    vecs[1]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max"};
    vecs[2]  = '{MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulhsu_m1x2"};
    vecs[3]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_m1xm1"};
    vecs[4]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min2"};
    vecs[5]  = '{MUL,    32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 33, "mul_x9"};
    vecs[6]  = '{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div_m7_2"};
    vecs[7]  = '{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem_m7_2"};
    vecs[8]  = '{DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2"};
    vecs[9]  = '{REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, "rem_7_m2"};
    vecs[10] = '{DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33, "divu_100_7"};
    vecs[11] = '{REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33, "remu_100_7"};
    vecs[12] = '{DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "divu_nosp"};
    vecs[13] = '{DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1,  "divu_zero"};
    vecs[14] = '{REM,    32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1,  "rem_zero"};
    vecs[15] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf"};

    rst                  = 1'b0;
    mif.m_extension_load = 1'b0;
    mif.funct3           = MUL;
    mif.rs1_data         = 32'd0;
    mif.rs2_data         = 32'd0;
    mif.advance          = 1'b0;
    mif.flush            = 1'b0;
    #12;
    check("reset_resp",   {31'd0, mif.m_extension_resp}, 32'd0);
    check("reset_result", mif.m_extension_result, 32'd0);
    check("reset_busy",   {31'd0, mif.busy}, 32'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
    end
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");

    // DONE held through a 5-cycle stall, then a back-to-back second MUL
    @(posedge clk); #1;
    mif.funct3 = MUL; mif.rs1_data = 32'd3; mif.rs2_data = 32'd5;
    mif.m_extension_load = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    check("hold_resp0",   {31'd0, mif.m_extension_resp}, 32'd1);
    check("hold_result0", mif.m_extension_result, 32'h0000_000F);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_resp",   {31'd0, mif.m_extension_resp}, 32'd1);
      check("hold_result", mif.m_extension_result, 32'h0000_000F);
      check("hold_norestart", {31'd0, mif.busy}, 32'd0);
    end
    mif.advance = 1'b1;
    @(posedge clk); #1;
    mif.advance = 1'b0;
    mif.rs1_data = 32'd6; mif.rs2_data = 32'd7;
    check("b2b_idle", {30'd0, mif.m_extension_resp, mif.busy}, 32'd0);
    repeat (32) @(posedge clk);
    #1;
    check("b2b_early", {31'd0, mif.m_extension_resp}, 32'd0);
    @(posedge clk); #1;
    check("b2b_resp",   {31'd0, mif.m_extension_resp}, 32'd1);
    check("b2b_result", mif.m_extension_result, 32'h0000_002A);
    mif.advance = 1'b1;
    @(posedge clk); #1;
    mif.advance = 1'b0;
    mif.m_extension_load = 1'b0;

    // flush in BUSY cycle 10
    @(posedge clk); #1;
    mif.funct3 = MULHU; mif.rs1_data = 32'h1111_1111; mif.rs2_data = 32'h2222_2222;
    mif.m_extension_load = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_before", {31'd0, mif.busy}, 32'd1);
    mif.flush = 1'b1;
    @(posedge clk); #1;
    check("flush_idle", {30'd0, mif.m_extension_resp, mif.busy}, 32'd0);
    mif.flush = 1'b0;
    mif.m_extension_load = 1'b0;
    seen_resp = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      seen_resp = seen_resp | mif.m_extension_resp;
    end
    check("flush_no_resp", {31'd0, seen_resp}, 32'd0);

    // async reset in BUSY cycle 20
    @(posedge clk); #1;
    mif.funct3 = DIVU; mif.rs1_data = 32'd1000; mif.rs2_data = 32'd3;
    mif.m_extension_load = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_busy_before", {31'd0, mif.busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_busy",   {31'd0, mif.busy}, 32'd0);
    check("rst_resp",   {31'd0, mif.m_extension_resp}, 32'd0);
    check("rst_result", mif.m_extension_result, 32'd0);
    mif.m_extension_load = 1'b0;
    @(negedge clk) rst = 1'b1;
    run_op(DIVU, 32'd1000, 32'd3, 32'd333, 33, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
